coeff_reg_bank: RTL and testbench

COEFF_REG_BANK -- requirements
Module: coeff_reg_bank

---
 rtl/coeff_reg_pkg.sv | 41 ++++
 rtl/coeff_pipe.sv | 45 ++++
 rtl/coeff_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_coeff_reg_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_reg_pkg.sv
// -----------------------------------------------------------------------------
// coeff_reg_pkg
//
// Shared constants and types for the canny coefficient register map.
// The defaults below describe the map as seen by the host: a small bank of
// DW-bit coefficient registers starting at CANNY_BASE, one register every
// CANNY_STRIDE bytes.
//
// Contents:
//   CANNY_DW / CANNY_AW   - register data width / bus address width
//   CANNY_NREG            - number of coefficient registers
//   CANNY_BASE            - byte address of register 0
//   CANNY_STRIDE          - address step between registers (power of two)
//   CANNY_OREG            - default output pipeline depth on the coefficient bus
//   MAX_NREG              - largest bank size the decoder is sized for
//   acc_dec_t             - decoded view of one bus access
//   idx_width()           - register index width for a bank of n registers
// -----------------------------------------------------------------------------
package coeff_reg_pkg;

    localparam int unsigned CANNY_DW     = 8;
    localparam int unsigned CANNY_AW     = 32;
    localparam int unsigned CANNY_NREG   = 4;
    localparam logic [31:0] CANNY_BASE   = 32'h1000_1234;
    localparam int unsigned CANNY_STRIDE = 4;
    localparam int unsigned CANNY_OREG   = 1;
    localparam int unsigned MAX_NREG     = 64;

    // One bus access after address decode.
    typedef struct packed {
        logic rd;   // read strobe present
        logic wr;   // write strobe present
        logic hit;  // address lands on a register of this bank
    } acc_dec_t;

    // A bank of one register still needs a one-bit index to address it.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : coeff_reg_pkg

// File: rtl/coeff_pipe.sv
// -----------------------------------------------------------------------------
// coeff_pipe
//
// Fixed-latency delay line for a wide bus. DEPTH = 0 is a plain wire; any
// other depth inserts that many register stages, all cleared by the
// asynchronous reset so nothing stale emerges after reset.
//
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous active-high reset
//   din   in   W   bus entering the delay line
//   dout  out  W   din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module coeff_pipe #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_reg
        logic [W-1:0] stage_p [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_p[i] <= '0;
                end
            end else begin
                stage_p[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_p[i] <= stage_p[i-1];
                end
            end
        end

        assign dout = stage_p[DEPTH-1];
    end

endmodule : coeff_pipe

// File: rtl/coeff_reg_bank.sv
// -----------------------------------------------------------------------------
// coeff_reg_bank
//
// Double-buffered coefficient register bank. The host writes a shadow copy
// through a simple strobe bus; frame_sync copies the whole shadow into the
// active copy at a frame boundary so the datapath never sees a half-updated
// coefficient set. With IMM = 1 writes go straight to the active copy.
// Reads always return the shadow copy, one cycle after the strobe.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous active-high reset
//   reg_wea     in   1        write strobe
//   reg_rea     in   1        read strobe
//   reg_addr    in   AW       access address
//   reg_wdata   in   DW       write data
//   frame_sync  in   1        commit pulse (frame boundary)
//   reg_rdata   out  DW       read data, 0 whenever reg_rvalid is low
//   reg_rvalid  out  1        read response pulse
//   reg_err     out  1        address-miss pulse (read or write)
//   pending     out  1        shadow holds an uncommitted write
//   reg_coeff   out  NREG*DW  active coefficients, register i at [i*DW +: DW],
//                             delayed by OREG cycles
// -----------------------------------------------------------------------------
module coeff_reg_bank
    import coeff_reg_pkg::*;
#(
    parameter int unsigned     DW     = CANNY_DW,
    parameter int unsigned     AW     = CANNY_AW,
    parameter int unsigned     NREG   = CANNY_NREG,
    parameter logic [AW-1:0]   BASE   = AW'(CANNY_BASE),
    parameter int unsigned     STRIDE = CANNY_STRIDE,
    parameter int unsigned     OREG   = CANNY_OREG,
    parameter int unsigned     IMM    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_wea,
    input  logic                 reg_rea,
    input  logic [AW-1:0]        reg_addr,
    input  logic [DW-1:0]        reg_wdata,
    input  logic                 frame_sync,
    output logic [DW-1:0]        reg_rdata,
    output logic                 reg_rvalid,
    output logic                 reg_err,
    output logic                 pending,
    output logic [NREG*DW-1:0]   reg_coeff
);

    localparam int unsigned   IW     = idx_width(NREG);
    localparam int unsigned   SSH    = $clog2(STRIDE);
    localparam logic [AW-1:0] SMASK  = AW'(STRIDE - 1);
    localparam logic [AW-1:0] NREG_A = AW'(NREG);
    localparam bit            IMM_EN = (IMM != 0);

    logic [DW-1:0]      shadow [NREG];
    logic [DW-1:0]      active [NREG];
    logic               pending_q;

    logic [AW-1:0]      off;
    logic [AW-1:0]      idx_full;
    logic [IW-1:0]      idx;
    acc_dec_t           acc;
    logic               wr_hit;
    logic               rd_hit;
    logic               miss;
    logic               commit;

    logic [DW-1:0]      rdata_p0;
    logic               vld_p0;
    logic               err_p0;

    logic [NREG*DW-1:0] active_flat;

    // Address decode. The subtraction wraps for addresses below BASE, so the
    // explicit >= test is what rejects them; stride alignment is a mask test
    // because STRIDE is a power of two.
    always_comb begin
        off      = reg_addr - BASE;
        idx_full = off >> SSH;
        idx      = idx_full[IW-1:0];
        acc.rd   = reg_rea;
        acc.wr   = reg_wea;
        acc.hit  = (reg_addr >= BASE) && ((off & SMASK) == '0) && (idx_full < NREG_A);
    end

    assign wr_hit = acc.wr & acc.hit;
    assign rd_hit = acc.rd & acc.hit;
    assign miss   = (acc.rd | acc.wr) & ~acc.hit;

    // A commit only happens when something is actually uncommitted; in
    // immediate mode frame_sync has nothing to do.
    assign commit = !IMM_EN && frame_sync && pending_q;

    // Register state. The commit copies the pre-edge shadow, so a write on
    // the same edge lands only in the shadow and leaves pending set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (commit) begin
                for (int i = 0; i < int'(NREG); i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_hit) begin
                shadow[idx] <= reg_wdata;
                if (IMM_EN) begin
                    active[idx] <= reg_wdata;
                end
            end
            if (IMM_EN) begin
                pending_q <= 1'b0;
            end else if (wr_hit) begin
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    // ---- stage p0: read / error response ----
    // Sampling the shadow before its update gives read-before-write when a
    // read and a write hit the same register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
            err_p0   <= 1'b0;
        end else begin
            rdata_p0 <= rd_hit ? shadow[idx] : '0;
            vld_p0   <= acc.rd;
            err_p0   <= miss;
        end
    end

    assign reg_rdata  = rdata_p0;
    assign reg_rvalid = vld_p0;
    assign reg_err    = err_p0;
    assign pending    = pending_q;

    always_comb begin
        active_flat = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            active_flat[i*DW +: DW] = active[i];
        end
    end

    // ---- stages p1..pOREG: coefficient output delay ----
    coeff_pipe #(
        .W     (NREG * DW),
        .DEPTH (OREG)
    ) u_coeff_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (active_flat),
        .dout (reg_coeff)
    );

endmodule : coeff_reg_bank

// File: tb/tb_coeff_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_coeff_reg_bank
//
// Directed stimulus drives two banks (commit mode and immediate mode, both
// OREG = 1). Each stimulus step pushes its hand-computed expectations into a
// response queue or a state queue, tagged with the cycle they are due; a
// separate monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_coeff_reg_bank;

    localparam logic [31:0] B = 32'h1000_1234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        we = 1'b0, re = 1'b0, fs = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  wd = '0;
    logic [7:0]  rdata;
    logic        rvalid, err, pend;
    logic [31:0] coeff;

    logic        i_we = 1'b0, i_re = 1'b0, i_fs = 1'b0;
    logic [31:0] i_addr = '0;
    logic [7:0]  i_wd = '0;
    logic [7:0]  i_rdata;
    logic        i_rvalid, i_err, i_pend;
    logic [31:0] i_coeff;

    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done  = 1'b0;

    typedef struct {
        int         due;
        logic       rv;
        logic [7:0] rd;
        logic       er;
    } rsp_t;

    typedef struct {
        int          due;
        bit          imm;
        logic [31:0] c;
        logic        p;
    } st_t;

    rsp_t rsp_q[$];
    st_t  st_q[$];

    coeff_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wea    (we),
        .reg_rea    (re),
        .reg_addr   (addr),
        .reg_wdata  (wd),
        .frame_sync (fs),
        .reg_rdata  (rdata),
        .reg_rvalid (rvalid),
        .reg_err    (err),
        .pending    (pend),
        .reg_coeff  (coeff)
    );

    coeff_reg_bank #(.IMM(1)) dut_imm (
        .clk        (clk),
        .rst        (rst),
        .reg_wea    (i_we),
        .reg_rea    (i_re),
        .reg_addr   (i_addr),
        .reg_wdata  (i_wd),
        .frame_sync (i_fs),
        .reg_rdata  (i_rdata),
        .reg_rvalid (i_rvalid),
        .reg_err    (i_err),
        .pending    (i_pend),
        .reg_coeff  (i_coeff)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [7:0] d, input logic f);
        @(negedge clk);
        we = w; re = r; addr = a; wd = d; fs = f;
        i_we = 1'b0; i_fs = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic drive_i(input logic w, input logic [31:0] a,
                           input logic [7:0] d, input logic f);
        @(negedge clk);
        i_we = w; i_addr = a; i_wd = d; i_fs = f;
        we = 1'b0; re = 1'b0; fs = 1'b0;
    endtask

    task automatic exp_rsp(input int off, input logic rv, input logic [7:0] rd, input logic er);
        rsp_t e;
        e.due = cyc + off; e.rv = rv; e.rd = rd; e.er = er;
        rsp_q.push_back(e);
    endtask

    task automatic exp_st(input int off, input bit imm, input logic [31:0] c, input logic p);
        st_t e;
        e.due = cyc + off; e.imm = imm; e.c = c; e.p = p;
        st_q.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        rsp_t        r;
        st_t         s;
        logic [31:0] gc;
        logic        gp;

        while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
            r = rsp_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL rsp_missing cyc=%0d: got no response, required rvalid=%0b rdata=%02h err=%0b",
                     r.due, r.rv, r.rd, r.er);
        end

        if (rvalid || err) begin
            n_cmp++;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                if (rvalid !== r.rv || rdata !== r.rd || err !== r.er) begin
                    n_bad++;
                    $display("FAIL rsp cyc=%0d: got rvalid=%0b rdata=%02h err=%0b, required rvalid=%0b rdata=%02h err=%0b",
                             cyc, rvalid, rdata, err, r.rv, r.rd, r.er);
                end
            end else begin
                n_bad++;
                $display("FAIL rsp_unexpected cyc=%0d: got rvalid=%0b rdata=%02h err=%0b, required no response",
                         cyc, rvalid, rdata, err);
            end
        end else begin
            n_cmp++;
            if (rdata !== 8'h00) begin
                n_bad++;
                $display("FAIL idle_rdata cyc=%0d: got %02h, required 00", cyc, rdata);
            end
        end

        while (st_q.size() > 0 && st_q[0].due <= cyc) begin
            s = st_q.pop_front();
            n_cmp++;
            gc = s.imm ? i_coeff : coeff;
            gp = s.imm ? i_pend  : pend;
            if (s.due != cyc || gc !== s.c || gp !== s.p) begin
                n_bad++;
                $display("FAIL state%s cyc=%0d due=%0d: got coeff=%08h pending=%0b, required coeff=%08h pending=%0b",
                         s.imm ? "_imm" : "", cyc, s.due, gc, gp, s.c, s.p);
            end
        end

        if (done) begin
            n_cmp++;
            if (rsp_q.size() != 0 || st_q.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: got %0d responses / %0d states outstanding, required 0 / 0",
                         rsp_q.size(), st_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus by 100000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Strobes under reset must be ignored; outputs held at 0.
        drive(1'b1, 1'b1, B + 4, 8'hFF, 1'b1);
        exp_st(1, 1'b0, 32'h0, 1'b0);
        exp_st(1, 1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b1, B + 4, 8'hFF, 1'b1);
        idle();
        rst = 1'b0;
        drive(1'b0, 1'b1, B + 4, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h00, 1'b0);
        exp_st(1, 1'b0, 32'h0, 1'b0);

        // Write then read back; active untouched until commit.
        drive(1'b1, 1'b0, B + 4, 8'h5A, 1'b0);
        drive(1'b0, 1'b1, B + 4, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h5A, 1'b0);
        exp_st(1, 1'b0, 32'h0, 1'b1);

        // Commit: visible on reg_coeff one cycle after the commit edge.
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        exp_st(1, 1'b0, 32'h0000_0000, 1'b0);
        exp_st(2, 1'b0, 32'h0000_5A00, 1'b0);
        idle();

        // Misses: misaligned, past the bank, below BASE.
        drive(1'b1, 1'b0, B + 2, 8'h77, 1'b0);
        exp_rsp(1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, B + 16, 8'h77, 1'b0);
        exp_rsp(1, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, B + 16, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, B, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h00, 1'b0);
        exp_st(1, 1'b0, 32'h0000_5A00, 1'b0);
        drive(1'b1, 1'b0, B - 4, 8'h77, 1'b0);
        exp_rsp(1, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, B + 4, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h5A, 1'b0);

        // Write with frame_sync while nothing pending: no commit.
        drive(1'b1, 1'b0, B, 8'h11, 1'b1);
        exp_st(1, 1'b0, 32'h0000_5A00, 1'b1);
        exp_st(2, 1'b0, 32'h0000_5A00, 1'b1);
        idle();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        exp_st(1, 1'b0, 32'h0000_5A00, 1'b0);
        exp_st(2, 1'b0, 32'h0000_5A11, 1'b0);
        idle();

        // Write coincident with a real commit: commit takes pre-write shadow.
        drive(1'b1, 1'b0, B + 8, 8'h22, 1'b0);
        drive(1'b1, 1'b0, B + 12, 8'h33, 1'b1);
        exp_st(2, 1'b0, 32'h0022_5A11, 1'b1);
        idle();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        exp_st(2, 1'b0, 32'h3322_5A11, 1'b0);
        idle();

        // Read during write to same register returns old value.
        drive(1'b1, 1'b1, B + 8, 8'h99, 1'b0);
        exp_rsp(1, 1'b1, 8'h22, 1'b0);
        drive(1'b0, 1'b1, B + 8, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h99, 1'b0);
        exp_st(1, 1'b0, 32'h3322_5A11, 1'b1);

        // Back-to-back reads every cycle.
        drive(1'b0, 1'b1, B, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h11, 1'b0);
        drive(1'b0, 1'b1, B + 4, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h5A, 1'b0);
        drive(1'b0, 1'b1, B + 8, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h99, 1'b0);
        drive(1'b0, 1'b1, B + 12, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'h33, 1'b0);

        // Asynchronous reset between edges with a read and commit in flight.
        drive(1'b1, 1'b0, B + 4, 8'hEE, 1'b0);
        drive(1'b0, 1'b1, B, 8'h00, 1'b1);
        exp_st(1, 1'b0, 32'h0, 1'b0);
        exp_st(1, 1'b1, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        we = 1'b0; re = 1'b0; fs = 1'b0;
        idle();
        idle();
        drive(1'b1, 1'b0, B + 4, 8'hAB, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b1, B + 4, 8'h00, 1'b0);
        exp_rsp(1, 1'b1, 8'hAB, 1'b0);
        exp_st(1, 1'b0, 32'h0, 1'b1);
        idle();

        // Immediate-mode bank.
        drive_i(1'b1, B + 12, 8'hC3, 1'b0);
        exp_st(1, 1'b1, 32'h0000_0000, 1'b0);
        exp_st(2, 1'b1, 32'hC300_0000, 1'b0);
        idle();
        drive_i(1'b1, B, 8'h44, 1'b1);
        exp_st(1, 1'b1, 32'hC300_0000, 1'b0);
        exp_st(2, 1'b1, 32'hC300_0044, 1'b0);

        repeat (4) idle();
        done = 1'b1;
    end

endmodule : tb_coeff_reg_bank
